// File: rtl/ofifo_col_pkg.sv
// Shared sizing defaults for the output FIFO between the systolic array and the SFU.
package ofifo_col_pkg;
  localparam int PSUM_BW     = 16;
  localparam int COL         = 8;
  localparam int OFIFO_DEPTH = 64;
  localparam int PTR_W       = $clog2(OFIFO_DEPTH);
endpackage

// File: rtl/ofifo_lane.sv
// Single-column circular FIFO with a registered (synchronous) read port.
module ofifo_lane
  import ofifo_col_pkg::*;
#(
  parameter int psum_bw = PSUM_BW,
  parameter int depth   = OFIFO_DEPTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [psum_bw-1:0]       din,
  output logic [psum_bw-1:0]       dout,
  output logic [$clog2(depth):0]   count
);
  localparam int ptr_w = $clog2(depth);

  logic [psum_bw-1:0] mem_r [depth];
  logic [ptr_w-1:0]   wr_ptr_r;
  logic [ptr_w-1:0]   rd_ptr_r;
  logic [ptr_w:0]     count_r;
  logic [psum_bw-1:0] dout_r;

  // Storage array; left unreset since pointer reset makes old entries unreachable.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Pointers, occupancy and the read register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_r <= {ptr_w{1'b0}};
      rd_ptr_r <= {ptr_w{1'b0}};
      count_r  <= {(ptr_w+1){1'b0}};
      dout_r   <= {psum_bw{1'b0}};
    end else begin
      if (push) begin
        wr_ptr_r <= wr_ptr_r + ptr_w'(1);
      end
      if (pop) begin
        rd_ptr_r <= rd_ptr_r + ptr_w'(1);
        dout_r   <= mem_r[rd_ptr_r];
      end
      if (push && !pop) begin
        count_r <= count_r + (ptr_w+1)'(1);
      end else if (pop && !push) begin
        count_r <= count_r - (ptr_w+1)'(1);
      end else begin
        count_r <= count_r;
      end
    end
  end

  assign dout  = dout_r;
  assign count = count_r;
endmodule

// File: rtl/ofifo_col.sv
// Per-column output FIFO: lanes fill independently, rows pop only when all lanes hold data.
module ofifo_col
  import ofifo_col_pkg::*;
#(
  parameter int psum_bw = PSUM_BW,
  parameter int col     = COL,
  parameter int depth   = OFIFO_DEPTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [col-1:0]         wr,
  input  logic [psum_bw*col-1:0] in,
  input  logic                   rd,
  output logic [psum_bw*col-1:0] out,
  output logic                   o_valid,
  output logic                   o_full,
  output logic                   o_ready,
  output logic [col-1:0]         o_ovf
);
  localparam int cnt_w = $clog2(depth) + 1;
  localparam logic [cnt_w-1:0] full_cnt = cnt_w'(depth);

  logic [cnt_w-1:0] count_s [col];
  logic [col-1:0]   nonempty_s;
  logic [col-1:0]   full_s;
  logic [col-1:0]   push_s;
  logic [col-1:0]   drop_s;
  logic             pop_s;
  logic [col-1:0]   ovf_r;

  // Per-lane status and push/drop decisions; a pop frees a slot in a full lane.
  always_comb begin
    nonempty_s = {col{1'b0}};
    full_s     = {col{1'b0}};
    push_s     = {col{1'b0}};
    drop_s     = {col{1'b0}};
    for (int g = 0; g < col; g++) begin
      nonempty_s[g] = (count_s[g] != {cnt_w{1'b0}});
      full_s[g]     = (count_s[g] == full_cnt);
      push_s[g]     = wr[g] & (~full_s[g] | pop_s);
      drop_s[g]     = wr[g] & full_s[g] & ~pop_s;
    end
  end

  assign o_valid = &nonempty_s;
  assign o_full  = |full_s;
  assign o_ready = ~o_full;
  assign pop_s   = rd & o_valid;

  // Sticky overflow flags, cleared only by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovf_r <= {col{1'b0}};
    end else begin
      ovf_r <= ovf_r | drop_s;
    end
  end

  assign o_ovf = ovf_r;

  for (genvar g = 0; g < col; g++) begin : g_lane
    ofifo_lane #(
      .psum_bw (psum_bw),
      .depth   (depth)
    ) u_lane (
      .clk   (clk),
      .reset (reset),
      .push  (push_s[g]),
      .pop   (pop_s),
      .din   (in[psum_bw*g +: psum_bw]),
      .dout  (out[psum_bw*g +: psum_bw]),
      .count (count_s[g])
    );
  end
endmodule

// File: tb/tb_ofifo_col.sv
// Directed self-checking bench for ofifo_col (psum_bw=16, col=8, depth=64).
module tb_ofifo_col;
  logic         clk;
  logic         reset;
  logic [7:0]   wr;
  logic [127:0] in;
  logic         rd;
  logic [127:0] out;
  logic         o_valid;
  logic         o_full;
  logic         o_ready;
  logic [7:0]   o_ovf;

  int checks = 0;
  int errors = 0;

  ofifo_col #(.psum_bw(16), .col(8), .depth(64)) dut (
    .clk     (clk),
    .reset   (reset),
    .wr      (wr),
    .in      (in),
    .rd      (rd),
    .out     (out),
    .o_valid (o_valid),
    .o_full  (o_full),
    .o_ready (o_ready),
    .o_ovf   (o_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // lane g gets base + g*step
  function automatic logic [127:0] row(input logic [15:0] base, input logic [15:0] step);
    logic [127:0] r;
    r = 128'd0;
    for (int g = 0; g < 8; g++) begin
      r[16*g +: 16] = base + 16'(g) * step;
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [127:0] prev;
    reset = 1'b0;
    wr    = 8'h00;
    in    = 128'd0;
    rd    = 1'b0;

    // 1: reset and idle
    tick();
    tick();
    check("rst_out", out, 128'd0);
    check("rst_valid", {127'd0, o_valid}, 128'd0);
    check("rst_ready", {127'd0, o_ready}, 128'd1);
    check("rst_full", {127'd0, o_full}, 128'd0);
    check("rst_ovf", {120'd0, o_ovf}, 128'd0);
    reset = 1'b1;
    tick();
    tick();
    check("idle_out", out, 128'd0);
    check("idle_valid", {127'd0, o_valid}, 128'd0);

    // 2: skewed fill, one lane per cycle
    for (int k = 0; k < 8; k++) begin
      wr = 8'(1 << k);
      in = row(16'h0100, 16'h0001);
      tick();
      check($sformatf("skew_valid_%0d", k), {127'd0, o_valid}, (k == 7) ? 128'd1 : 128'd0);
    end
    wr = 8'hFF;
    in = row(16'hFFF0, 16'h0001);
    tick();
    wr = 8'h00;
    rd = 1'b1;
    tick();
    rd = 1'b0;
    check("skew_row0", out, row(16'h0100, 16'h0001));
    check("skew_valid_after1", {127'd0, o_valid}, 128'd1);
    rd = 1'b1;
    tick();
    rd = 1'b0;
    check("skew_row1_neg", out, row(16'hFFF0, 16'h0001));
    check("skew_valid_after2", {127'd0, o_valid}, 128'd0);

    // 3: partial row must not pop
    wr = 8'h7F;
    in = row(16'h2000, 16'h0001);
    tick();
    wr = 8'h00;
    check("part_valid", {127'd0, o_valid}, 128'd0);
    rd = 1'b1;
    tick();
    rd = 1'b0;
    check("part_rd_ignored", out, row(16'hFFF0, 16'h0001));
    wr = 8'h80;
    tick();
    wr = 8'h00;
    check("part_valid_after7", {127'd0, o_valid}, 128'd1);
    rd = 1'b1;
    tick();
    rd = 1'b0;
    check("part_row", out, row(16'h2000, 16'h0001));
    check("part_empty", {127'd0, o_valid}, 128'd0);
    check("part_ovf", {120'd0, o_ovf}, 128'd0);

    // 4: fill all lanes to depth, then overflow lane 3
    for (int i = 0; i < 64; i++) begin
      wr = 8'hFF;
      in = row(16'(i), 16'h1000);
      tick();
      if (i == 62) check("fill_notfull", {127'd0, o_full}, 128'd0);
    end
    wr = 8'h00;
    check("fill_full", {127'd0, o_full}, 128'd1);
    check("fill_ready", {127'd0, o_ready}, 128'd0);
    check("fill_ovf_none", {120'd0, o_ovf}, 128'd0);
    wr = 8'h08;
    in = {128{1'b1}};
    tick();
    wr = 8'h00;
    check("ovf_lane3", {120'd0, o_ovf}, 128'h08);

    // 5: push+pop on full FIFO across pointer wrap
    for (int c = 0; c < 200; c++) begin
      wr = 8'hFF;
      rd = 1'b1;
      in = row(16'(64 + c), 16'h1000);
      tick();
      check($sformatf("stream_row_%0d", c), out, row(16'(c), 16'h1000));
      check($sformatf("stream_full_%0d", c), {127'd0, o_full}, 128'd1);
    end
    wr = 8'h00;
    check("stream_ovf_sticky", {120'd0, o_ovf}, 128'h08);
    for (int c = 0; c < 64; c++) begin
      tick();
      check($sformatf("drain_row_%0d", c), out, row(16'(200 + c), 16'h1000));
    end
    rd = 1'b0;
    check("drain_empty", {127'd0, o_valid}, 128'd0);
    check("drain_notfull", {127'd0, o_full}, 128'd0);
    prev = out;
    tick();
    check("drain_hold", out, prev);

    // 6: reset mid-stream with rows buffered
    for (int i = 0; i < 11; i++) begin
      wr = 8'hFF;
      in = row(16'h5000 + 16'(i), 16'h0100);
      tick();
    end
    wr = 8'h00;
    rd = 1'b1;
    tick();
    rd = 1'b0;
    check("mid_row", out, row(16'h5000, 16'h0100));
    #2;
    reset = 1'b0;
    #1;
    check("mid_rst_out", out, 128'd0);
    check("mid_rst_valid", {127'd0, o_valid}, 128'd0);
    check("mid_rst_ovf", {120'd0, o_ovf}, 128'd0);
    tick();
    reset = 1'b1;
    tick();
    check("post_rst_valid", {127'd0, o_valid}, 128'd0);
    wr = 8'hFF;
    in = row(16'h6000, 16'h0001);
    tick();
    wr = 8'h00;
    check("post_rst_valid1", {127'd0, o_valid}, 128'd1);
    rd = 1'b1;
    tick();
    rd = 1'b0;
    check("post_rst_row", out, row(16'h6000, 16'h0001));
    check("post_rst_empty", {127'd0, o_valid}, 128'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
